// File: rtl/unified_int_queue_p.sv
// unified_int_queue_p
//   Age-ordered, fully compacting integer/branch issue queue. Holds up to
//   DEPTH renamed micro-ops, snoops NUM_WK wakeup buses and issues up to two
//   ready ops per cycle. Port 0 takes non-branch ops only. Port 1 takes any op.
//   Both issue ports use valid/ready handshakes and are registered.
//
// Ports
//   cpu_clk_i, cpu_rst_ni     clock, asynchronous active-low reset
//   flush_i                   clears queue and issue valids at the next edge
//   dp_vld_i / dp_data_i      two dispatch slots, each {branch, rs1, rs2, rob};
//                             slot 0 is older and sits in the low half
//   dp_rs*_vld_i / _rdy_i     per-slot source-used and source-ready flags
//   dp_busy_o                 [0] no free entry, [1] fewer than two free entries
//   wk_tag_i / wk_vld_i       wakeup buses
//   iss0_* / iss1_*           issue ports; data is {rs2, rs1, rob}
//
// Optional feature
//   UIQ_OCC_COUNT_EN          adds registered occupancy output occ_o
module unified_int_queue_p #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 6,
  parameter int ROB_W  = 6,
  parameter int NUM_WK = 3
) (
  input  logic                              cpu_clk_i,
  input  logic                              cpu_rst_ni,
  input  logic                              flush_i,
  input  logic [1:0]                        dp_vld_i,
  input  logic [2*(1+2*TAG_W+ROB_W)-1:0]    dp_data_i,
  input  logic [1:0]                        dp_rs1_vld_i,
  input  logic [1:0]                        dp_rs2_vld_i,
  input  logic [1:0]                        dp_rs1_rdy_i,
  input  logic [1:0]                        dp_rs2_rdy_i,
  output logic [1:0]                        dp_busy_o,
  input  logic [NUM_WK*TAG_W-1:0]           wk_tag_i,
  input  logic [NUM_WK-1:0]                 wk_vld_i,
  output logic                              iss0_vld_o,
  output logic [2*TAG_W+ROB_W-1:0]          iss0_data_o,
  input  logic                              iss0_rdy_i,
  output logic                              iss1_vld_o,
  output logic [2*TAG_W+ROB_W-1:0]          iss1_data_o,
  input  logic                              iss1_rdy_i
`ifdef UIQ_OCC_COUNT_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]        occ_o
`endif
);

  localparam int SLOT_W = 1 + 2*TAG_W + ROB_W;
  localparam int ISS_W  = 2*TAG_W + ROB_W;
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Queue state
  logic [DEPTH-1:0] vld_q, br_q, av1_q, av2_q;
  logic [TAG_W-1:0] rs1_q [DEPTH];
  logic [TAG_W-1:0] rs2_q [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH];

  logic [DEPTH-1:0] vld_n, br_n, av1_n, av2_n;
  logic [TAG_W-1:0] rs1_n [DEPTH];
  logic [TAG_W-1:0] rs2_n [DEPTH];
  logic [ROB_W-1:0] rob_n [DEPTH];

  logic [DEPTH-1:0] match1, match2, ready, take0, take1;
  logic [CNT_W-1:0] cnt_q, wr;
  logic             load0, load1, found0, found1;
  logic [ISS_W-1:0] data0, data1;

  logic             d_br  [2];
  logic [TAG_W-1:0] d_rs1 [2];
  logic [TAG_W-1:0] d_rs2 [2];
  logic [ROB_W-1:0] d_rob [2];
  logic [1:0]       d_av1, d_av2, accept;

  function automatic logic wk_hit(input logic [TAG_W-1:0]        tag,
                                  input logic [NUM_WK*TAG_W-1:0] tags,
                                  input logic [NUM_WK-1:0]       vlds);
    logic hit;
    hit = 1'b0;
    for (int j = 0; j < NUM_WK; j++) begin
      if (vlds[j] && (tags[j*TAG_W +: TAG_W] == tag)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Wakeup matches count toward readiness in the same cycle.
  always_comb begin
    match1 = '0;
    match2 = '0;
    ready  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match1[i] = wk_hit(rs1_q[i], wk_tag_i, wk_vld_i);
      match2[i] = wk_hit(rs2_q[i], wk_tag_i, wk_vld_i);
      ready[i]  = vld_q[i] & (av1_q[i] | match1[i]) & (av2_q[i] | match2[i]);
    end
  end

  // Busy flags come from registered occupancy only; issue this cycle does
  // not free space for dispatch this cycle.
  always_comb begin
    cnt_q = '0;
    for (int i = 0; i < DEPTH; i++) cnt_q = cnt_q + CNT_W'(vld_q[i]);
    dp_busy_o[0] = (cnt_q == DEPTH_C);
    dp_busy_o[1] = (cnt_q >= (DEPTH_C - CNT_W'(1)));
  end

  assign load0 = !iss0_vld_o || iss0_rdy_i;
  assign load1 = !iss1_vld_o || iss1_rdy_i;

  // Oldest-first select. Port 0 skips branches; port 1 then takes the oldest
  // remaining ready op, which may be a non-branch if port 0 passed it over.
  always_comb begin
    take0  = '0;
    take1  = '0;
    found0 = 1'b0;
    found1 = 1'b0;
    data0  = '0;
    data1  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (load0 && !found0 && ready[i] && !br_q[i]) begin
        found0   = 1'b1;
        take0[i] = 1'b1;
        data0    = {rs2_q[i], rs1_q[i], rob_q[i]};
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (load1 && !found1 && ready[i] && !take0[i]) begin
        found1   = 1'b1;
        take1[i] = 1'b1;
        data1    = {rs2_q[i], rs1_q[i], rob_q[i]};
      end
    end
  end

  // Dispatch slot decode and initial operand availability.
  always_comb begin
    d_av1  = '0;
    d_av2  = '0;
    accept = '0;
    for (int k = 0; k < 2; k++) begin
      d_br[k]   = dp_data_i[k*SLOT_W + SLOT_W - 1];
      d_rs1[k]  = dp_data_i[k*SLOT_W + ROB_W + TAG_W +: TAG_W];
      d_rs2[k]  = dp_data_i[k*SLOT_W + ROB_W +: TAG_W];
      d_rob[k]  = dp_data_i[k*SLOT_W +: ROB_W];
      d_av1[k]  = !dp_rs1_vld_i[k] || dp_rs1_rdy_i[k] ||
                  wk_hit(d_rs1[k], wk_tag_i, wk_vld_i);
      d_av2[k]  = !dp_rs2_vld_i[k] || dp_rs2_rdy_i[k] ||
                  wk_hit(d_rs2[k], wk_tag_i, wk_vld_i);
      accept[k] = dp_vld_i[k] && !dp_busy_o[k];
    end
  end

  // Next queue image: survivors packed down in age order, then accepted
  // dispatch slots appended. The write pointer never passes the source index,
  // so any number of holes collapse in one pass.
  always_comb begin
    vld_n = '0;
    br_n  = '0;
    av1_n = '0;
    av2_n = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rs1_n[i] = '0;
      rs2_n[i] = '0;
      rob_n[i] = '0;
    end
    wr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && !take0[i] && !take1[i]) begin
        vld_n[wr[IDX_W-1:0]] = 1'b1;
        br_n[wr[IDX_W-1:0]]  = br_q[i];
        av1_n[wr[IDX_W-1:0]] = av1_q[i] | match1[i];
        av2_n[wr[IDX_W-1:0]] = av2_q[i] | match2[i];
        rs1_n[wr[IDX_W-1:0]] = rs1_q[i];
        rs2_n[wr[IDX_W-1:0]] = rs2_q[i];
        rob_n[wr[IDX_W-1:0]] = rob_q[i];
        wr = wr + CNT_W'(1);
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (accept[k] && (wr < DEPTH_C)) begin
        vld_n[wr[IDX_W-1:0]] = 1'b1;
        br_n[wr[IDX_W-1:0]]  = d_br[k];
        av1_n[wr[IDX_W-1:0]] = d_av1[k];
        av2_n[wr[IDX_W-1:0]] = d_av2[k];
        rs1_n[wr[IDX_W-1:0]] = d_rs1[k];
        rs2_n[wr[IDX_W-1:0]] = d_rs2[k];
        rob_n[wr[IDX_W-1:0]] = d_rob[k];
        wr = wr + CNT_W'(1);
      end
    end
    if (flush_i) vld_n = '0;
  end

  // Queue entry registers.
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      vld_q <= '0;
      br_q  <= '0;
      av1_q <= '0;
      av2_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rs1_q[i] <= '0;
        rs2_q[i] <= '0;
        rob_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_n;
      br_q  <= br_n;
      av1_q <= av1_n;
      av2_q <= av2_n;
      for (int i = 0; i < DEPTH; i++) begin
        rs1_q[i] <= rs1_n[i];
        rs2_q[i] <= rs2_n[i];
        rob_q[i] <= rob_n[i];
      end
    end
  end

  // Issue registers. A stalled port does not load, so its data holds.
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) begin
      iss0_vld_o  <= 1'b0;
      iss0_data_o <= '0;
      iss1_vld_o  <= 1'b0;
      iss1_data_o <= '0;
    end else if (flush_i) begin
      iss0_vld_o <= 1'b0;
      iss1_vld_o <= 1'b0;
    end else begin
      if (load0) begin
        iss0_vld_o <= found0;
        if (found0) iss0_data_o <= data0;
      end
      if (load1) begin
        iss1_vld_o <= found1;
        if (found1) iss1_data_o <= data1;
      end
    end
  end

`ifdef UIQ_OCC_COUNT_EN
  // Occupancy mirrors the next entry-valid population.
  always_ff @(posedge cpu_clk_i or negedge cpu_rst_ni) begin
    if (!cpu_rst_ni) occ_o <= '0;
    else if (flush_i) occ_o <= '0;
    else              occ_o <= wr;
  end
`endif

endmodule

// File: tb/tb_unified_int_queue_p.sv
// Directed, table-driven bench for unified_int_queue_p (default parameters).
// Each table row is one clock: inputs are driven on the falling edge and the
// registered outputs are compared just after the following rising edge.
module tb_unified_int_queue_p;

  localparam int DEPTH  = 8;
  localparam int TAG_W  = 6;
  localparam int ROB_W  = 6;
  localparam int NUM_WK = 3;
  localparam int SLOT_W = 1 + 2*TAG_W + ROB_W;
  localparam int ISS_W  = 2*TAG_W + ROB_W;
  localparam int WK_W   = NUM_WK*TAG_W;

  logic              clk, rst_n, flush;
  logic [1:0]        dp_vld, rs1_vld, rs2_vld, rs1_rdy, rs2_rdy, busy;
  logic [2*SLOT_W-1:0] dp_data;
  logic [WK_W-1:0]   wk_tag;
  logic [NUM_WK-1:0] wk_vld;
  logic              iss0_vld, iss1_vld, iss0_rdy, iss1_rdy;
  logic [ISS_W-1:0]  iss0_data, iss1_data;
`ifdef UIQ_OCC_COUNT_EN
  logic [$clog2(DEPTH+1)-1:0] occ;
`endif

  unified_int_queue_p #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ROB_W(ROB_W), .NUM_WK(NUM_WK)) dut (
    .cpu_clk_i    (clk),
    .cpu_rst_ni   (rst_n),
    .flush_i      (flush),
    .dp_vld_i     (dp_vld),
    .dp_data_i    (dp_data),
    .dp_rs1_vld_i (rs1_vld),
    .dp_rs2_vld_i (rs2_vld),
    .dp_rs1_rdy_i (rs1_rdy),
    .dp_rs2_rdy_i (rs2_rdy),
    .dp_busy_o    (busy),
    .wk_tag_i     (wk_tag),
    .wk_vld_i     (wk_vld),
    .iss0_vld_o   (iss0_vld),
    .iss0_data_o  (iss0_data),
    .iss0_rdy_i   (iss0_rdy),
    .iss1_vld_o   (iss1_vld),
    .iss1_data_o  (iss1_data),
    .iss1_rdy_i   (iss1_rdy)
`ifdef UIQ_OCC_COUNT_EN
    ,
    .occ_o        (occ)
`endif
  );

  typedef struct {
    logic              fl;
    logic [1:0]        dv;
    logic [SLOT_W-1:0] o0, o1;
    logic [1:0]        r1v, r1r, r2v, r2r;
    logic [NUM_WK-1:0] wv;
    logic [WK_W-1:0]   wt;
    logic              q0, q1;
    logic              e0v;
    logic [ISS_W-1:0]  e0d;
    logic              e1v;
    logic [ISS_W-1:0]  e1d;
    logic [1:0]        eb;
    int                eo;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [SLOT_W-1:0] op(input int br, input int rs1, input int rs2, input int rob);
    return {1'(br), TAG_W'(rs1), TAG_W'(rs2), ROB_W'(rob)};
  endfunction

  function automatic logic [ISS_W-1:0] iss(input int rs2, input int rs1, input int rob);
    return {TAG_W'(rs2), TAG_W'(rs1), ROB_W'(rob)};
  endfunction

  function automatic logic [WK_W-1:0] wk(input int j, input int tag);
    logic [WK_W-1:0] w;
    w = '0;
    w[j*TAG_W +: TAG_W] = TAG_W'(tag);
    return w;
  endfunction

  task automatic add(input logic fl, input logic [1:0] dv,
                     input logic [SLOT_W-1:0] o0, input logic [SLOT_W-1:0] o1,
                     input logic [1:0] r1v, input logic [1:0] r1r,
                     input logic [1:0] r2v, input logic [1:0] r2r,
                     input logic [NUM_WK-1:0] wv, input logic [WK_W-1:0] wt,
                     input logic q0, input logic q1,
                     input logic e0v, input logic [ISS_W-1:0] e0d,
                     input logic e1v, input logic [ISS_W-1:0] e1d,
                     input logic [1:0] eb, input int eo);
    vec_t v;
    v.fl = fl;   v.dv = dv;   v.o0 = o0;   v.o1 = o1;
    v.r1v = r1v; v.r1r = r1r; v.r2v = r2v; v.r2r = r2r;
    v.wv = wv;   v.wt = wt;   v.q0 = q0;   v.q1 = q1;
    v.e0v = e0v; v.e0d = e0d; v.e1v = e1v; v.e1d = e1d;
    v.eb = eb;   v.eo = eo;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic applyStimulus(input vec_t v);
    flush    = v.fl;
    dp_vld   = v.dv;
    dp_data  = {v.o1, v.o0};
    rs1_vld  = v.r1v;
    rs1_rdy  = v.r1r;
    rs2_vld  = v.r2v;
    rs2_rdy  = v.r2r;
    wk_vld   = v.wv;
    wk_tag   = v.wt;
    iss0_rdy = v.q0;
    iss1_rdy = v.q1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    check($sformatf("v%0d iss0_vld", idx), 32'(iss0_vld), 32'(v.e0v));
    check($sformatf("v%0d iss1_vld", idx), 32'(iss1_vld), 32'(v.e1v));
    check($sformatf("v%0d busy", idx), 32'(busy), 32'(v.eb));
    if (v.e0v) check($sformatf("v%0d iss0_data", idx), 32'(iss0_data), 32'(v.e0d));
    if (v.e1v) check($sformatf("v%0d iss1_data", idx), 32'(iss1_data), 32'(v.e1d));
`ifdef UIQ_OCC_COUNT_EN
    check($sformatf("v%0d occ", idx), 32'(occ), 32'(v.eo));
`endif
  endtask

  initial begin
    vec_t idle;
    // 1-2: two ready ALU ops, issued together one cycle after dispatch
    add(1'b0, 2'b11, op(0,1,2,1), op(0,3,4,2), 2'b11,2'b11,2'b11,2'b11, 3'b000,'0, 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b00, 2);
    add(1'b0, 2'b00, '0,'0, 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b1,iss(2,1,1), 1'b1,iss(4,3,2), 2'b00, 0);
    // 3-5: branch must go to port 1 even though it is older
    add(1'b0, 2'b11, op(1,5,6,5), op(0,7,8,6), 2'b11,2'b11,2'b11,2'b11, 3'b000,'0, 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b00, 2);
    add(1'b0, 2'b00, '0,'0, 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b1,iss(8,7,6), 1'b1,iss(6,5,5), 2'b00, 0);
    add(1'b0, 2'b00, '0,'0, 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b00, 0);
    // 6-9: rs1=0x12 waits; a near-miss tag 0x32 must not wake it; bus 2 does
    add(1'b0, 2'b01, op(0,'h12,'h13,9), '0, 2'b01,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b00, 1);
    add(1'b0, 2'b00, '0,'0, 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b00, 1);
    add(1'b0, 2'b00, '0,'0, 2'b00,2'b00,2'b00,2'b00, 3'b100,wk(2,'h32), 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b00, 1);
    add(1'b0, 2'b00, '0,'0, 2'b00,2'b00,2'b00,2'b00, 3'b100,wk(2,'h12), 1'b1,1'b1,
        1'b1,iss('h13,'h12,9), 1'b0,'0, 2'b00, 0);
    // 10-11: wakeup seen on the dispatch cycle is captured; branch to port 1
    add(1'b0, 2'b01, op(1,'h20,'h21,10), '0, 2'b01,2'b00,2'b01,2'b01, 3'b001,wk(0,'h20), 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b00, 1);
    add(1'b0, 2'b00, '0,'0, 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b0,'0, 1'b1,iss('h21,'h20,10), 2'b00, 0);
    // 12-16: fill with ops waiting on 0x30; busy at 7 and 8 entries
    add(1'b0, 2'b11, op(0,'h30,11,11), op(0,'h30,12,12), 2'b11,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b00, 2);
    add(1'b0, 2'b11, op(0,'h30,13,13), op(0,'h30,14,14), 2'b11,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b00, 4);
    add(1'b0, 2'b11, op(0,'h30,15,15), op(0,'h30,16,16), 2'b11,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b00, 6);
    add(1'b0, 2'b01, op(0,'h30,17,17), '0, 2'b11,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b10, 7);
    add(1'b0, 2'b01, op(0,'h30,18,18), '0, 2'b11,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b11, 8);
    // 17-20: wake all, then stall port 1 while port 0 drains in age order
    add(1'b0, 2'b00, '0,'0, 2'b00,2'b00,2'b00,2'b00, 3'b010,wk(1,'h30), 1'b1,1'b1,
        1'b1,iss(11,'h30,11), 1'b1,iss(12,'h30,12), 2'b00, 6);
    add(1'b0, 2'b00, '0,'0, 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b0,
        1'b1,iss(13,'h30,13), 1'b1,iss(12,'h30,12), 2'b00, 5);
    add(1'b0, 2'b00, '0,'0, 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b0,
        1'b1,iss(14,'h30,14), 1'b1,iss(12,'h30,12), 2'b00, 4);
    add(1'b0, 2'b00, '0,'0, 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b1,iss(15,'h30,15), 1'b1,iss(16,'h30,16), 2'b00, 2);
    // 21-23: both ports stalled, refill to full
    add(1'b0, 2'b11, op(0,'h31,20,20), op(0,'h31,21,21), 2'b11,2'b00,2'b00,2'b00, 3'b000,'0, 1'b0,1'b0,
        1'b1,iss(15,'h30,15), 1'b1,iss(16,'h30,16), 2'b00, 4);
    add(1'b0, 2'b11, op(0,'h31,22,22), op(0,'h31,23,23), 2'b11,2'b00,2'b00,2'b00, 3'b000,'0, 1'b0,1'b0,
        1'b1,iss(15,'h30,15), 1'b1,iss(16,'h30,16), 2'b00, 6);
    add(1'b0, 2'b11, op(0,'h31,24,24), op(0,'h31,25,25), 2'b11,2'b00,2'b00,2'b00, 3'b000,'0, 1'b0,1'b0,
        1'b1,iss(15,'h30,15), 1'b1,iss(16,'h30,16), 2'b11, 8);
    // 24-26: flush clears everything and discards a same-cycle dispatch
    add(1'b1, 2'b00, '0,'0, 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b0,1'b0,
        1'b0,'0, 1'b0,'0, 2'b00, 0);
    add(1'b1, 2'b01, op(0,1,2,26), '0, 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b00, 0);
    add(1'b0, 2'b00, '0,'0, 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b00, 0);
    // 27-28: normal operation resumes after flush
    add(1'b0, 2'b11, op(0,1,2,27), op(0,3,4,28), 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b00, 2);
    add(1'b0, 2'b00, '0,'0, 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b1,iss(2,1,27), 1'b1,iss(4,3,28), 2'b00, 0);
    // 29-31: port 0 stalled, port 1 takes the non-branch op
    add(1'b0, 2'b11, op(0,1,2,30), op(0,3,4,31), 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b0,'0, 1'b0,'0, 2'b00, 2);
    add(1'b0, 2'b01, op(0,5,6,32), '0, 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b1,1'b1,
        1'b1,iss(2,1,30), 1'b1,iss(4,3,31), 2'b00, 1);
    add(1'b0, 2'b00, '0,'0, 2'b00,2'b00,2'b00,2'b00, 3'b000,'0, 1'b0,1'b1,
        1'b1,iss(2,1,30), 1'b1,iss(6,5,32), 2'b00, 0);

    // Reset state
    idle = vecs[4];
    rst_n = 1'b0;
    applyStimulus(idle);
    #12;
    check("reset iss0_vld", 32'(iss0_vld), 32'd0);
    check("reset iss1_vld", 32'(iss1_vld), 32'd0);
    check("reset iss0_data", 32'(iss0_data), 32'd0);
    check("reset iss1_data", 32'(iss1_data), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
`ifdef UIQ_OCC_COUNT_EN
    check("reset occ", 32'(occ), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkOutput(vecs[i], i + 1);
    end

    // Asynchronous reset takes effect without a clock edge
    @(negedge clk);
    applyStimulus(idle);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset iss0_vld", 32'(iss0_vld), 32'd0);
    check("async reset iss1_vld", 32'(iss1_vld), 32'd0);
    check("async reset iss0_data", 32'(iss0_data), 32'd0);
    check("async reset iss1_data", 32'(iss1_data), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
